// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 8E1 frame).
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_START_BIT = 1'b0;
  localparam logic        UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Word handshake into the UART transmitter: valid/ready with 8-bit payload.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last clk cycle of each bit period.
// Shared with the receiver side.
module uart_baud_tick #(
  parameter int unsigned CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running count within a bit, restarted by clear or at each boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// One-entry holding buffer lets back-to-back frames go out with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ     = 50000000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  uart_transmitter_if.slave  tx_if,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  uart_tx_state_t            state;
  logic [UART_DATA_BITS-1:0] tx_word;
  logic [UART_DATA_BITS-1:0] hold_data;
  logic                      hold_full;
  logic [2:0]                bit_cnt;
  logic                      tick;
  logic                      accept;
  logic                      stop_end;

  assign tx_if.tx_ready = enable & ~hold_full;
  assign accept         = tx_if.tx_valid & tx_if.tx_ready;
  assign stop_end       = (state == STOP) & tick;

  uart_baud_tick #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == IDLE) | ~enable),
    .tick  (tick)
  );

  // Frame sequencer with holding buffer; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_word    <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      tx         <= UART_STOP_BIT;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      tx         <= UART_STOP_BIT;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Accepts that cannot go straight to the shifter park in the buffer
      if (accept && (state != IDLE) && !stop_end) begin
        hold_data <= tx_if.tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            tx_word <= tx_if.tx_data;
            tx      <= UART_START_BIT;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= tx_word[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= uart_even_parity(tx_word);
              state   <= PARITY;
`else
              tx      <= UART_STOP_BIT;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= tx_word[bit_cnt + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= UART_STOP_BIT;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            frame_done <= 1'b1;
            // Buffered word wins; otherwise a same-edge accept goes straight out
            if (hold_full) begin
              tx_word   <= hold_data;
              hold_full <= 1'b0;
              tx        <= UART_START_BIT;
              state     <= START;
            end else if (accept) begin
              tx_word <= tx_if.tx_data;
              tx      <= UART_START_BIT;
              state   <= START;
            end else begin
              tx    <= UART_STOP_BIT;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter with CYCLES_PER_BIT = 4.
// Honours UART_TX_PARITY_EN to match the DUT build.
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic clk;
  logic rst;
  logic enable;
  logic tx;
  logic busy;
  logic frame_done;

  uart_transmitter_if ifc ();

  uart_transmitter #(.CYCLES_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tx_if      (ifc),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Line monitor: decodes each frame mid-bit and checks it against the scoreboard
  logic [10:0] mon_fb;
  logic        mon_abort;
  logic [7:0]  mon_exp;
  always begin
    @(negedge clk);
    if (!rst && enable && tx === 1'b0) begin
      mon_fb = '1;
      mon_abort = 1'b0;
      for (int c = 1; c < FRAME; c++) begin
        if (c % CPB == 1) mon_fb[c/CPB] = tx;
        @(negedge clk);
        if (rst || !enable) mon_abort = 1'b1;
      end
      if (!mon_abort) begin
        chk("mon frame expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          chk("mon start bit", 32'(mon_fb[0]), 32'd0);
          chk("mon data", 32'(mon_fb[8:1]), 32'(mon_exp));
`ifdef UART_TX_PARITY_EN
          chk("mon parity", 32'(mon_fb[9]), 32'(^mon_exp));
`endif
          chk("mon stop bit", 32'(mon_fb[NB-1]), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word from idle and check the full waveform cycle by cycle
  task automatic run_frame(input logic [7:0] d, input string tag);
    logic [10:0] ef;
    int bad;
    int done_at;
    int pulses;
    ef = build_frame(d);
    chk({tag, " ready before"}, 32'(ifc.tx_ready), 32'd1);
    ifc.tx_data = d;
    ifc.tx_valid = 1'b1;
    sb.push_back(d);
    step();
    ifc.tx_valid = 1'b0;
    bad = 0;
    done_at = -1;
    pulses = 0;
    for (int k = 0; k < FRAME + 8; k++) begin
      if (k < FRAME && tx !== ef[k/CPB]) bad++;
      if (k < FRAME && busy !== 1'b1) bad++;
      if (frame_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k == FRAME) chk({tag, " busy after"}, 32'(busy), 32'd0);
      step();
    end
    chk({tag, " waveform"}, 32'(bad), 32'd0);
    chk({tag, " frame_done cycle"}, 32'(done_at), 32'(FRAME));
    chk({tag, " frame_done pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int pulses;
    int k;
    rst = 1'b1;
    enable = 1'b1;
    ifc.tx_valid = 1'b0;
    ifc.tx_data = '0;
    #2;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset tx_ready", 32'(ifc.tx_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("idle tx", 32'(tx), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle frame_done", 32'(frame_done), 32'd0);
    chk("idle tx_ready", 32'(ifc.tx_ready), 32'd1);

    run_frame(8'h55, "0x55");
    run_frame(8'h07, "0x07");
    run_frame(8'h00, "0x00");
    run_frame(8'hFF, "0xFF");

    // Back-to-back: second word offered on the cycle after the first
    ifc.tx_data = 8'hA5;
    ifc.tx_valid = 1'b1;
    sb.push_back(8'hA5);
    step();
    chk("b2b first start", 32'(tx), 32'd0);
    chk("b2b ready for second", 32'(ifc.tx_ready), 32'd1);
    ifc.tx_data = 8'h3C;
    sb.push_back(8'h3C);
    step();
    ifc.tx_valid = 1'b0;
    chk("b2b ready dropped", 32'(ifc.tx_ready), 32'd0);
    chk("b2b busy", 32'(busy), 32'd1);
    k = 1;
    while (frame_done !== 1'b1 && k < FRAME + 10) begin
      if (k == FRAME - 1) chk("b2b ready low before drain", 32'(ifc.tx_ready), 32'd0);
      step();
      k++;
    end
    chk("b2b frame_done cycle", 32'(k), 32'(FRAME));
    chk("b2b second start on frame_done", 32'(tx), 32'd0);
    chk("b2b ready returns", 32'(ifc.tx_ready), 32'd1);
    chk("b2b busy held", 32'(busy), 32'd1);
    for (int i = 0; i < FRAME + 6; i++) step();
    chk("b2b busy end", 32'(busy), 32'd0);
    chk("b2b scoreboard drained", 32'(sb.size()), 32'd0);

    // Abort in DATA bit 3 with a word buffered
    ifc.tx_data = 8'h96;
    ifc.tx_valid = 1'b1;
    step();
    ifc.tx_data = 8'h11;
    step();
    ifc.tx_valid = 1'b0;
    chk("abort buffer full", 32'(ifc.tx_ready), 32'd0);
    for (int i = 2; i <= 17; i++) step();
    chk("abort pre tx d3", 32'(tx), 32'd0);
    enable = 1'b0;
    step();
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort frame_done", 32'(frame_done), 32'd0);
    chk("abort ready with enable low", 32'(ifc.tx_ready), 32'd0);
    step();
    enable = 1'b1;
    step();
    chk("abort buffer empty", 32'(ifc.tx_ready), 32'd1);
    bad = 0;
    pulses = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      if (frame_done === 1'b1) pulses++;
      step();
    end
    chk("abort line stays idle", 32'(bad), 32'd0);
    chk("abort no frame_done", 32'(pulses), 32'd0);
    sb.delete();
    run_frame(8'hC3, "after abort");

    // Async reset during the stop bit with a word buffered
    ifc.tx_data = 8'h5A;
    ifc.tx_valid = 1'b1;
    sb.push_back(8'h5A);
    step();
    ifc.tx_data = 8'hE1;
    step();
    ifc.tx_valid = 1'b0;
    chk("rst buffer full", 32'(ifc.tx_ready), 32'd0);
    for (int i = 2; i <= FRAME - 2; i++) step();
    chk("rst pre stop bit", 32'(tx), 32'd1);
    chk("rst pre busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async tx", 32'(tx), 32'd1);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async frame_done", 32'(frame_done), 32'd0);
    chk("rst async buffer empty", 32'(ifc.tx_ready), 32'd1);
    step();
    rst = 1'b0;
    bad = 0;
    pulses = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      if (frame_done === 1'b1) pulses++;
      step();
    end
    chk("rst buffered word discarded", 32'(bad), 32'd0);
    chk("rst no frame_done", 32'(pulses), 32'd0);
    sb.delete();
    run_frame(8'h3C, "after reset");
    chk("final scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
